// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle for imm_gen_pipe: decode request in, extended immediate out.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both 1;
// a source holds valid and its payload unchanged until that beat, and ready never depends on valid.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_data;
    logic [TAG_W-1:0] out_tag;
    logic             imm_illegal;
    logic [CNT_W-1:0] illegal_count;
    logic [1:0]       dbg_state;

    modport master (
        output in_valid, instruction, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, imm_data, out_tag, imm_illegal, illegal_count, dbg_state
    );

    modport slave (
        input  in_valid, instruction, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, imm_data, out_tag, imm_illegal, illegal_count, dbg_state
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode at the input, a main
// register plus one skid register on the output, and a saturating illegal-format counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  main_imm_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] main_tag_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             main_ill_q;
    logic             skid_ill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      ins;
    logic [31:0]      imm32_d;
    logic [XLEN-1:0]  imm_d;
    logic             ill_d;
    logic             accept;
    logic             xfer;
    logic             unused_opcode;

    assign ins           = bus.instruction;
    assign unused_opcode = ^ins[6:0];
    assign accept        = bus.in_valid & in_ready_q;
    assign xfer          = out_valid_q & bus.out_ready;

    always_comb begin
        imm32_d = '0;
        ill_d   = 1'b0;
        case (bus.ImmSrc)
            3'b000: imm32_d = {{20{ins[31]}}, ins[31:20]};
            3'b001: imm32_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'b010: imm32_d = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            3'b011: imm32_d = {ins[31:12], 12'b0};
            3'b100: imm32_d = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            3'b101: begin
                if (XLEN == 64) imm32_d = {26'b0, ins[25:20]};
                else            imm32_d = {27'b0, ins[24:20]};
            end
            3'b110: imm32_d = {27'b0, ins[19:15]};
            default: ill_d = 1'b1;
        endcase
    end

    // Signed formats carry their sign in bit 31; zero-extended formats leave it clear.
    always_comb begin
        imm_d        = {XLEN{imm32_d[31]}};
        imm_d[31:0]  = imm32_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_imm_q  <= '0;
            main_tag_q  <= '0;
            main_ill_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
            skid_ill_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept && ill_d && !flush && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;

            if (flush) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            main_imm_q  <= imm_d;
                            main_tag_q  <= bus.in_tag;
                            main_ill_q  <= ill_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && xfer) begin
                            main_imm_q <= imm_d;
                            main_tag_q <= bus.in_tag;
                            main_ill_q <= ill_d;
                        end else if (accept) begin
                            // Output is stalled, so the newcomer parks behind it.
                            skid_imm_q <= imm_d;
                            skid_tag_q <= bus.in_tag;
                            skid_ill_q <= ill_d;
                            in_ready_q <= 1'b0;
                            state_q    <= TWO;
                        end else if (xfer) begin
                            out_valid_q <= 1'b0;
                            state_q     <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (xfer) begin
                            main_imm_q <= skid_imm_q;
                            main_tag_q <= skid_tag_q;
                            main_ill_q <= skid_ill_q;
                            in_ready_q <= 1'b1;
                            state_q    <= ONE;
                        end
                    end
                    default: begin
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.imm_data      = main_imm_q;
    assign bus.out_tag       = main_tag_q;
    assign bus.imm_illegal   = main_ill_q;
    assign bus.illegal_count = cnt_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the pipelined RV32I/RV64I core. It extracts and sign- or zero-extends the immediate of every RISC-V base format, including U, J, shift-amount and CSR zimm, which the single-cycle core does not decode. Transfers on both sides use valid/ready handshakes through a two-entry skid buffer. A saturating counter records illegal-format requests.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (PC or instruction ID) carried alongside each immediate.
- CNT_W, 16, width of the illegal-format counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards all held entries; synchronous.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept; registered.
- instruction  in  32  raw instruction word.
- ImmSrc  in  3  format select, see Operation.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- imm_data  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the current output entry.
- imm_illegal  out  1  current output entry used ImmSrc=111.
- illegal_count  out  CNT_W  saturating count of accepted illegal requests.

## Operation
- Accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
- ImmSrc decode. s = instruction[31], replicated to XLEN.
  - 000 I: {s, instruction[31:20]}.
  - 001 S: {s, [31:25], [11:7]}.
  - 010 B: {s, [7], [30:25], [11:8], 0}.
  - 011 U: {s above bit 31, [31:12], 12'b0}. On XLEN=64, bits 63:32 are copies of bit 31.
  - 100 J: {s, [19:12], [20], [30:21], 0}.
  - 101 SHAMT: zero-extended instruction[24:20] when XLEN=32, instruction[25:20] when XLEN=64.
  - 110 ZIMM: zero-extended instruction[19:15].
  - 111 illegal: imm_data=0, imm_illegal=1. Every other code gives imm_illegal=0.
- Codes 000–010 remain bit-compatible with the single-cycle core's 2-bit encoding when the top bit is 0.
- Immediate computation is combinational on the input side. The result, the tag and the illegal flag are captured at accept.
- Storage is a main (output) register plus one skid register. States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register valid, skid empty, in_ready=1.
  - TWO: both registers valid, in_ready=0.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no output transfer → TWO. The new entry goes to skid.
  - ONE + accept + output transfer → ONE. Main register reloads with the new entry.
  - ONE + output transfer, no accept → EMPTY.
  - TWO + output transfer → ONE. Skid moves to main.
- Entries leave in the order they were accepted; no duplication, no loss.
- flush: the next state is EMPTY regardless of accept. An accept in the flush cycle is discarded and does not count as illegal. in_ready returns to 1 in the next cycle.
- illegal_count increments by 1 on each accepted, non-flushed ImmSrc=111 request. It holds at 2^CNT_W−1. It is cleared only by reset; flush does not clear it.

## Timing
- Latency: 1 cycle from accept to out_valid on an empty pipe.
- Throughput: 1 per cycle while out_ready=1.
- in_ready is a register output with no combinational path from out_ready. It falls the cycle after entry to TWO and rises the cycle after leaving TWO.
- Hold rule: out_valid, imm_data, out_tag and imm_illegal stay stable while out_valid=1 and out_ready=0.
- Reset and flush:
  - Reset and flush each force EMPTY in the following cycle.
  - Reset values: out_valid=0, in_ready=1, imm_data=0, out_tag=0, imm_illegal=0, illegal_count=0.
  - An accept in the reset cycle is discarded.
  - Reset has priority over flush.
- Output fields with out_valid=0 are don't-care, except immediately after reset, where they are 0.

## Test plan
- XLEN=32, out_ready=1. Send 0xFFF00093/000, 0xFE20AE23/001, 0xFE000CE3/010, 0x123450B7/011, 0x001000EF/100 back-to-back. Required outputs, one cycle later each, one per cycle: 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000, 0x00000800.
- XLEN=64. 0xFFF00093/000 → 0xFFFFFFFFFFFFFFFF. 0x03F01013/101 → 0x3F. 0x800005B7/011 → 0xFFFFFFFF80000000.
- Backpressure. in_valid=1 with tags 1,2,3,4 while out_ready=0 for 3 cycles, then 1:
  - tags 1 and 2 are accepted; in_ready=0 from the third cycle;
  - outputs then appear in order 1,2,3,4 with no gap once out_ready=1.
- Illegal format. Three accepts with ImmSrc=111 → imm_data=0 and imm_illegal=1 on each; illegal_count=3. With CNT_W=2, a fourth and a fifth illegal accept leave the count at 3.
- Flush in state TWO, with a simultaneous accept of an illegal request → out_valid=0 and in_ready=1 next cycle; illegal_count unchanged.
- Reset asserted in state ONE with out_valid=1 → next cycle every output equals its reset value, including illegal_count=0.
